// File: rtl/dsp_cfg_scheduler_if.sv
// Software-side configuration bus of dsp_cfg_scheduler: shadow writes plus the commit pulse.
interface dsp_cfg_scheduler_if #(
    parameter int unsigned GW = 32
);
    logic          cfg_wr_valid;
    logic          cfg_wr_ready;
    logic [1:0]    cfg_wr_addr;
    logic [GW-1:0] cfg_wr_data;
    logic          cfg_commit;

    modport master (
        output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit,
        input  cfg_wr_ready
    );

    modport slave (
        input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit,
        output cfg_wr_ready
    );
endinterface

// File: rtl/dsp_cfg_scheduler.sv
// Applies shadowed CORDIC chain config atomically on a ce_down boundary, then ramps gain1.
// Optional WAIT_SLOT/RAMP watchdog enabled by defining DSP_CFG_TIMEOUT_EN.
module dsp_cfg_scheduler #(
    parameter int unsigned   PW        = 19,
    parameter int unsigned   GW        = 32,
    parameter logic [GW-1:0] GAIN_STEP = 32'h0100_0000,
    parameter logic [GW-1:0] GAIN_RST  = 32'h4000_0000,
    parameter int unsigned   TIMEOUT   = 4096
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    dsp_cfg_scheduler_if.slave cfg,
    input  logic               ce_down,
    output logic [PW-1:0]      phase_inc_nco,
    output logic [PW-1:0]      phase_inc_down,
    output logic [GW-1:0]      gain1,
    output logic [GW-1:0]      gain2,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_timeout
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_SLOT = 3'd1;
    localparam logic [2:0] APPLY     = 3'd2;
    localparam logic [2:0] RAMP      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] sh_nco_q, sh_down_q;
    logic [GW-1:0] sh_gain1_q, sh_gain2_q;
    logic [PW-1:0] nco_q, down_q;
    logic [GW-1:0] gain1_q, gain1_d, gain2_q;
    logic          wr_en;
    logic          slot_hit, step_hit;
    logic [GW:0]   diff, mag;
    logic          snap;
    logic [GW-1:0] ramp_next;

    assign wr_en = cfg.cfg_wr_valid && (state_q == IDLE);

    // Signed GW+1-bit distance to target; stepping stops short of it, so no wrap is possible.
    assign diff      = {1'b0, sh_gain1_q} - {1'b0, gain1_q};
    assign mag       = diff[GW] ? -diff : diff;
    assign snap      = (GAIN_STEP == '0) || (mag <= {1'b0, GAIN_STEP});
    assign ramp_next = snap ? sh_gain1_q
                     : (diff[GW] ? gain1_q - GAIN_STEP : gain1_q + GAIN_STEP);

`ifdef DSP_CFG_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          to_q, to_d;

    assign tick     = (cnt_q == CW'(TIMEOUT - 1));
    assign slot_hit = ce_down || tick;
    assign step_hit = ce_down || tick;

    always_comb begin
        cnt_d = '0;
        if ((state_q == WAIT_SLOT || state_q == RAMP) && !(ce_down || tick)) begin
            cnt_d = cnt_q + CW'(1);
        end
        to_d = to_q;
        if (state_q == IDLE && cfg.cfg_commit) begin
            to_d = 1'b0;
        end else if (state_q == WAIT_SLOT && tick && !ce_down) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign cfg_timeout = to_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign slot_hit       = ce_down;
    assign step_hit       = ce_down;
    assign cfg_timeout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gain1_d = gain1_q;
        case (state_q)
            IDLE:      if (cfg.cfg_commit) state_d = WAIT_SLOT;
            WAIT_SLOT: if (slot_hit) state_d = APPLY;
            APPLY:     state_d = (gain1_q == sh_gain1_q) ? DONE : RAMP;
            RAMP: begin
                if (step_hit) begin
                    gain1_d = ramp_next;
                    if (ramp_next == sh_gain1_q) state_d = DONE;
                end
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_nco_q   <= '0;
            sh_down_q  <= '0;
            sh_gain1_q <= GAIN_RST;
            sh_gain2_q <= GAIN_RST;
            nco_q      <= '0;
            down_q     <= '0;
            gain1_q    <= GAIN_RST;
            gain2_q    <= GAIN_RST;
        end else begin
            state_q <= state_d;
            gain1_q <= gain1_d;
            if (wr_en) begin
                case (cfg.cfg_wr_addr)
                    2'd0:    sh_nco_q   <= cfg.cfg_wr_data[PW-1:0];
                    2'd1:    sh_down_q  <= cfg.cfg_wr_data[PW-1:0];
                    2'd2:    sh_gain1_q <= cfg.cfg_wr_data;
                    default: sh_gain2_q <= cfg.cfg_wr_data;
                endcase
            end
            // All three live words switch on the same edge.
            if (state_q == APPLY) begin
                nco_q   <= sh_nco_q;
                down_q  <= sh_down_q;
                gain2_q <= sh_gain2_q;
            end
        end
    end

    assign cfg.cfg_wr_ready = (state_q == IDLE);
    assign phase_inc_nco    = nco_q;
    assign phase_inc_down   = down_q;
    assign gain1            = gain1_q;
    assign gain2            = gain2_q;
    assign cfg_busy         = (state_q != IDLE);
    assign cfg_done         = (state_q == DONE);
endmodule

// File: tb/tb_dsp_cfg_scheduler.sv
// Scoreboard bench for dsp_cfg_scheduler: randomized config transactions against a queue model.
module tb_dsp_cfg_scheduler;
    localparam int unsigned PW   = 19;
    localparam int unsigned GW   = 32;
    localparam logic [31:0] STEP = 32'h0100_0000;
    localparam logic [31:0] GRST = 32'h4000_0000;
`ifdef DSP_CFG_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 4096;
`endif

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          ce_down;
    logic [PW-1:0] phase_inc_nco, phase_inc_down;
    logic [GW-1:0] gain1, gain2;
    logic          cfg_busy, cfg_done, cfg_timeout;

    dsp_cfg_scheduler_if #(.GW(GW)) cfg_bus ();

    dsp_cfg_scheduler #(.PW(PW), .GW(GW), .TIMEOUT(TMO)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .cfg            (cfg_bus.slave),
        .ce_down        (ce_down),
        .phase_inc_nco  (phase_inc_nco),
        .phase_inc_down (phase_inc_down),
        .gain1          (gain1),
        .gain2          (gain2),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_timeout    (cfg_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_off = 1'b0;

    typedef struct { int cyc; logic [PW-1:0] nco; logic [PW-1:0] down; logic [GW-1:0] g2; } apply_t;
    typedef struct { int cyc; logic [GW-1:0] g1; } done_t;
    typedef struct { logic [1:0] a; logic [31:0] d; } wr_t;

    apply_t        apply_q[$];
    done_t         done_q[$];
    logic [GW-1:0] g1_q[$];
    wr_t           wq[$];

    // Reference model: shadow registers and the live gain1 the design should have settled on.
    logic [GW-1:0] sh[4];
    logic [GW-1:0] m_g1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sh[0] = '0; sh[1] = '0; sh[2] = GRST; sh[3] = GRST;
        m_g1  = GRST;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] rand_data(input logic [1:0] a);
        logic [31:0] d;
        if (a == 2'd2) d = GRST - 10 * STEP + $urandom_range(0, 20) * STEP + ($urandom & 32'h00FF_FFFF);
        else d = $urandom;
        return d;
    endfunction

    // Holds the write until the handshake edge; optionally carries commit and a ce_down.
    task automatic write(input logic [1:0] a, input logic [31:0] d, input bit cmt, input bit strb);
        bit rdy, ok;
        ok = 1'b0;
        cfg_bus.cfg_wr_valid = 1'b1;
        cfg_bus.cfg_wr_addr  = a;
        cfg_bus.cfg_wr_data  = d;
        cfg_bus.cfg_commit   = cmt;
        ce_down              = strb;
        for (int n = 0; n < 1000; n++) begin
            @(negedge sys_clk);
            rdy = cfg_bus.cfg_wr_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wr_ready_wait", 0, 1);
        else sh[a] = d;
        cfg_bus.cfg_wr_valid = 1'b0;
        cfg_bus.cfg_commit   = 1'b0;
        ce_down              = 1'b0;
    endtask

    // Called in the first WAIT_SLOT cycle after an accepted commit.
    task automatic finish_txn(input int gap, input bit noise, input bit hold);
        logic [GW-1:0] tgt, g;
        logic [GW-1:0] steps[$];
        logic [1:0]    ha;
        logic [31:0]   hd;
        bit            held;
        int            k, s;
        held = 1'b0;
        ha   = 2'($urandom_range(0, 3));
        hd   = rand_data(ha);
        tgt  = sh[2];
        g    = m_g1;
        while (g != tgt) begin
            if (tgt > g) g = (tgt - g <= STEP) ? tgt : g + STEP;
            else g = (g - tgt <= STEP) ? tgt : g - STEP;
            steps.push_back(g);
        end
        repeat (gap) tick();
        k       = cyc;
        ce_down = 1'b1;
        apply_q.push_back('{k + 2, sh[0][PW-1:0], sh[1][PW-1:0], sh[3]});
        tick();
        ce_down = noise;
        tick();
        ce_down = 1'b0;
        s       = k + 1;
        if (steps.size() == 0) done_q.push_back('{k + 2, tgt});
        foreach (steps[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            ce_down = 1'b1;
            if (noise) cfg_bus.cfg_commit = 1'($urandom_range(0, 1));
            if (hold && i == 0) begin
                held                 = 1'b1;
                cfg_bus.cfg_wr_valid = 1'b1;
                cfg_bus.cfg_wr_addr  = ha;
                cfg_bus.cfg_wr_data  = hd;
            end
            g1_q.push_back(steps[i]);
            s = cyc;
            tick();
            ce_down            = 1'b0;
            cfg_bus.cfg_commit = 1'b0;
        end
        if (steps.size() != 0) done_q.push_back('{s + 1, tgt});
        m_g1 = tgt;
        tick();
        if (held) write(ha, hd, 1'b0, 1'b0);
    endtask

    task automatic run_txn(input int gap, input bit cwl, input bit swc, input bit hold,
                           input bit noise);
        wr_t w;
        bit  use_cwl;
        use_cwl = cwl && (wq.size() > 0);
        while (wq.size() > (use_cwl ? 1 : 0)) begin
            w = wq.pop_front();
            write(w.a, w.d, 1'b0, 1'b0);
        end
        if (use_cwl) begin
            w = wq.pop_front();
            write(w.a, w.d, 1'b1, swc);
        end else begin
            cfg_bus.cfg_commit = 1'b1;
            ce_down            = swc;
            tick();
            cfg_bus.cfg_commit = 1'b0;
            ce_down            = 1'b0;
        end
        finish_txn(gap, noise, hold);
    endtask

    // Monitor: compares live outputs against the queued expectations.
    logic [PW-1:0] lnco, ldown;
    logic [GW-1:0] lg1, lg2;
    always @(negedge sys_clk) begin
        apply_t        a;
        done_t         d;
        logic [GW-1:0] e;
        if (!rst_n) begin
            lnco = '0; ldown = '0; lg1 = GRST; lg2 = GRST;
        end else if (!mon_off) begin
            check("wr_ready_vs_busy", cfg_bus.cfg_wr_ready, !cfg_busy);
`ifndef DSP_CFG_TIMEOUT_EN
            check("timeout_tied_low", cfg_timeout, 0);
`endif
            if (apply_q.size() > 0 && apply_q[0].cyc <= cyc) begin
                a = apply_q.pop_front();
                check("apply_cycle", cyc, a.cyc);
                check("apply_nco", phase_inc_nco, a.nco);
                check("apply_down", phase_inc_down, a.down);
                check("apply_gain2", gain2, a.g2);
                lnco = a.nco; ldown = a.down; lg2 = a.g2;
            end
            if ({phase_inc_nco, phase_inc_down, gain2} != {lnco, ldown, lg2})
                check("stray_apply_change", {phase_inc_nco, phase_inc_down, gain2},
                      {lnco, ldown, lg2});
            if (gain1 != lg1) begin
                if (g1_q.size() == 0) begin
                    check("gain1_stray_change", gain1, lg1);
                end else begin
                    e = g1_q.pop_front();
                    check("gain1_step", gain1, e);
                    lg1 = e;
                end
            end
            if (cfg_done) begin
                if (done_q.size() == 0) begin
                    check("done_stray", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_gain1", gain1, d.g1);
                    check("done_busy", cfg_busy, 1);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        wr_t w;
        int  c;
        cfg_bus.cfg_wr_valid = 1'b0;
        cfg_bus.cfg_wr_addr  = '0;
        cfg_bus.cfg_wr_data  = '0;
        cfg_bus.cfg_commit   = 1'b0;
        ce_down              = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("rst_nco", phase_inc_nco, 0);
        check("rst_down", phase_inc_down, 0);
        check("rst_gain1", gain1, GRST);
        check("rst_gain2", gain2, GRST);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_timeout", cfg_timeout, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Atomic apply, strobe 10 cycles after commit; strobe in the commit cycle is ignored.
        wq.push_back('{2'd0, 32'h0000_1000});
        wq.push_back('{2'd1, 32'h0000_2345});
        wq.push_back('{2'd3, 32'h2000_0000});
        run_txn(9, 1'b0, 1'b1, 1'b0, 1'b0);
        // Ramp up in 8 steps, with ignored commits and a write held while busy.
        wq.push_back('{2'd2, 32'h4800_0000});
        run_txn(2, 1'b0, 1'b0, 1'b1, 1'b1);
        wq.push_back('{2'd2, 32'h4000_0000});
        run_txn(1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Single snapping step just below unity.
        wq.push_back('{2'd2, 32'h3F80_0000});
        run_txn(0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Write and commit in one cycle.
        wq.push_back('{2'd3, 32'h1234_5678});
        wq.push_back('{2'd2, 32'h4100_0000});
        run_txn(3, 1'b1, 1'b0, 1'b0, 1'b1);
        // Range extremes: must snap without wrapping.
        wq.push_back('{2'd2, 32'hFFFF_FFFF});
        run_txn(1, 1'b1, 1'b0, 1'b0, 1'b0);
        wq.push_back('{2'd2, 32'h0000_0000});
        run_txn(1, 1'b1, 1'b0, 1'b0, 1'b0);
        wq.push_back('{2'd2, GRST});
        run_txn(1, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            for (int n = $urandom_range(0, 4); n > 0; n--) begin
                w.a = 2'($urandom_range(0, 3));
                w.d = rand_data(w.a);
                wq.push_back(w);
            end
            run_txn($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef DSP_CFG_TIMEOUT_EN
        write(2'd2, m_g1, 1'b0, 1'b0);
        cfg_bus.cfg_commit = 1'b1;
        tick();
        cfg_bus.cfg_commit = 1'b0;
        c = cyc - 1;
        apply_q.push_back('{c + TMO + 2, sh[0][PW-1:0], sh[1][PW-1:0], sh[3]});
        done_q.push_back('{c + TMO + 2, m_g1});
        repeat (TMO + 6) tick();
        check("timeout_set", cfg_timeout, 1);
        write(2'd3, $urandom, 1'b1, 1'b0);
        check("timeout_cleared", cfg_timeout, 0);
        finish_txn(2, 1'b0, 1'b0);
`else
        c = cyc;
`endif

        // Reset in the middle of a ramp.
        mon_off = 1'b1;
        write(2'd2, 32'h4A00_0000, 1'b1, 1'b0);
        tick();
        ce_down = 1'b1;
        tick();
        ce_down = 1'b0;
        tick();
        ce_down = 1'b1;
        repeat (3) tick();
        ce_down = 1'b0;
        check("pre_reset_busy", cfg_busy, 1);
        rst_n = 1'b0;
        @(negedge sys_clk);
        check("midramp_rst_gain1", gain1, GRST);
        check("midramp_rst_gain2", gain2, GRST);
        check("midramp_rst_nco", phase_inc_nco, 0);
        check("midramp_rst_down", phase_inc_down, 0);
        check("midramp_rst_busy", cfg_busy, 0);
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        mon_off = 1'b0;
        wq.push_back('{2'd2, 32'h4200_0000});
        wq.push_back('{2'd0, 32'h0005_A5A5});
        run_txn(2, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (4) tick();
        check("queues_drained", apply_q.size() + done_q.size() + g1_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
